alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the lab's combinational flag ALU.
- Keeps the single-cycle logic/arith op codes.
- Adds multi-cycle ops: shift-add multiply and bit-serial shifts.
- Uses a start/busy/done handshake, with result and N/Z/C/V flags held in registers.
- Sits between the lab's register file / switch inputs and the 7-segment/LED display path.

Parameters:
N, 8, operand/result width in bits (N >= 2)
CNT_W, $clog2(N+1), width of internal cycle/shift counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
control  input  4  op code, latched with operands on accepted start
A  input  N  operand A, latched on accepted start
B  input  N  operand B / shift amount, latched on accepted start
result  output  N  registered result, held until next done
N_flag  output  1  negative: result[N-1]
Z  output  1  zero: result == 0
C  output  1  carry/borrow/overflow-out, per op
V  output  1  signed overflow (ADD/SUB only)
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when result/flags update

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - result, N_flag, Z, C, V, busy, done all go to 0.
  - Internal operand, accumulator and counter registers are cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, EXEC, MUL, SHIFT, FIN.
- IDLE:
  - start=1 latches A, B and control, and sets busy=1.
  - Next state: EXEC for ops 0,1,2,4,5 and undefined codes; MUL for op 6; SHIFT for ops 7,8.
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 4 ADD, 5 SUB, 6 MUL (low N bits), 7 SHL, 8 SHR (logical).
  - All other codes: result 0, Z=1, C=V=0.
- EXEC: computes the result in one cycle, then goes to FIN.
- Width and flag rules:
  - ADD: {C,result} = A+B (N+1-bit); V = (A[N-1]==B[N-1]) && (result[N-1]!=A[N-1]).
  - SUB: result = A-B; C=1 iff A<B unsigned (borrow); V = (A[N-1]!=B[N-1]) && (result[N-1]!=A[N-1]).
  - Logic ops: C=V=0.
- MUL:
  - Shift-add over a 2N-bit accumulator, one multiplier bit per cycle, exactly N cycles, then FIN.
  - result = product[N-1:0]; C = |product[2N-1:N]; V=0.
- SHIFT:
  - Shifts one bit per cycle; count = min(B, N).
  - B=0: zero shift cycles, result=A, C=0.
  - C = last bit shifted out; if B >= N, result=0 and C = last bit shifted out after N shifts. V=0.
- FIN:
  - Registers result and flags, pulses done=1 for one cycle, clears busy, returns to IDLE.
  - N_flag and Z are derived from the registered result.
- Latency from accepted start to done pulse:
  - 2 cycles for EXEC ops.
  - N+2 cycles for MUL.
  - min(B,N)+2 cycles for SHIFT.
- start while busy=1 is ignored: no queueing, and latched operands are unaffected.
- start asserted in the cycle done pulses (state FIN) is ignored; start is accepted from IDLE on the following cycle.
- A, B and control may change freely after acceptance.
- result and flags change only in FIN or on reset.

Decomposition:
- alu_seq_pkg holds:
  - typedef enum op_t: OP_AND=0, OP_OR=1, OP_XOR=2, OP_ADD=4, OP_SUB=5, OP_MUL=6, OP_SHL=7, OP_SHR=8.
  - typedef enum state_t: IDLE, EXEC, MUL, SHIFT, FIN.
- One sub-module: alu_seq_comb (parametrised N). It is the pure combinational single-cycle unit for ops 0/1/2/4/5, producing result, C and V. It is instantiated in EXEC.
- The MUL and SHIFT datapaths and the FSM live in alu_seq.

Test Plan:
1. N=8, ADD A=0x7F B=0x01 -> done 2 cycles after start; result=0x80, N_flag=1, Z=0, C=0, V=1.
2. N=8, SUB A=0x00 B=0x01 -> result=0xFF, C=1 (borrow), V=0, N_flag=1; SUB A=0x80 B=0x01 -> result=0x7F, V=1, C=0.
3. N=8, MUL A=0x10 B=0x11 -> busy 9 cycles, done at cycle 10; result=0x10, C=1; MUL 0x03×0x05 -> 0x0F, C=0; start pulsed at cycle 4 ignored.
4. N=8, SHL A=0x81 B=1 -> result=0x02, C=1, latency 3; SHR A=0x81 B=0 -> result=0x81, C=0, latency 2; SHL A=0xFF B=12 -> result=0x00, Z=1, C=1, latency 10.
5. N=8, XOR A=0x5A B=0x5A -> result=0x00, Z=1, C=V=0; control=3 -> result=0, Z=1.
6. N=8, MUL started, rst asserted at cycle 4 -> result/flags/busy/done immediately 0, no done pulse; new ADD 0x02+0x03 after release -> result=0x05.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the registered sequential ALU.
//   op_t    - 4-bit operation codes carried on the control input
//   state_t - controller states of alu_seq
//   is_shift() - true for the bit-serial shift op codes
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_MUL = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    MUL   = 3'd2,
    SHIFT = 3'd3,
    FIN   = 3'd4
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: purely combinational single-cycle unit for AND/OR/XOR/ADD/SUB.
// Ports:
//   a, b  - N-bit operands
//   op    - 4-bit op code; any code it does not handle yields y=0, c=v=0
//   y     - N-bit result
//   c     - carry-out (ADD) or borrow (SUB), 0 otherwise
//   v     - signed overflow (ADD/SUB), 0 otherwise
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] y,
  output logic         c,
  output logic         v
);

  // One extra bit on each side so the top bit is carry (add) or borrow (sub).
  logic [N:0] sum;
  logic [N:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD: begin
        y = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        y = diff[N-1:0];
        c = diff[N];
        v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake.
// Single-cycle logic/arith ops go through alu_seq_comb; MUL is a shift-add
// over a 2N-bit accumulator (N steps); SHL/SHR shift one bit per cycle.
// Ports:
//   clk, rst          - clock (rising edge), async active-high reset
//   start             - request, only honoured in IDLE
//   control, A, B     - op code and operands, latched when start is accepted
//   result            - registered result, held until the next done
//   N_flag, Z, C, V   - registered flags, updated together with result
//   busy              - high from the cycle after acceptance until done
//   done              - one-cycle pulse while the new result is first visible
//   dbg_state         - current controller state (state_t encoding)
// Handshake: a start seen high at a rising edge while the controller is IDLE
// is accepted; at any other time it is dropped. busy rises on acceptance and
// falls in the same cycle done pulses; result/flags are valid while done=1
// and stay stable until the next done.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [3:0]     control,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   result,
  output logic           N_flag,
  output logic           Z,
  output logic           C,
  output logic           V,
  output logic           busy,
  output logic           done,
  output logic [2:0]     dbg_state
);

  localparam logic [N:0] NMAX = (N+1)'(N);

  state_t           state;
  logic [N-1:0]     a_q;     // operand A; doubles as the shift register
  logic [N-1:0]     b_q;     // operand B; doubles as the multiplier shifter
  logic [3:0]       op_q;
  logic [2*N-1:0]   acc;     // product accumulator
  logic [2*N-1:0]   mcand;   // multiplicand, moves left one bit per step
  logic             sc;      // last bit shifted out
  logic [CNT_W-1:0] cnt;     // remaining MUL/SHIFT steps

  logic [N-1:0]     y_c;
  logic             c_c;
  logic             v_c;

  // Values loaded into the output registers on the edge that enters FIN.
  logic             fin_go;
  logic [N-1:0]     fin_res;
  logic             fin_c;
  logic             fin_v;

  assign dbg_state = state;

  alu_seq_comb #(.N(N)) u_comb (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (y_c),
    .c  (c_c),
    .v  (v_c)
  );

  // Shift count saturates at N: beyond that every bit is already gone.
  function automatic logic [CNT_W-1:0] shift_count(input logic [N-1:0] amt);
    if ({1'b0, amt} >= NMAX) return CNT_W'(N);
    else                     return CNT_W'(amt);
  endfunction

  always_comb begin
    fin_go  = 1'b0;
    fin_res = y_c;
    fin_c   = c_c;
    fin_v   = v_c;
    case (state)
      EXEC: fin_go = 1'b1;
      MUL: begin
        fin_res = acc[N-1:0];
        fin_c   = |acc[2*N-1:N];
        fin_v   = 1'b0;
        fin_go  = (cnt == '0);
      end
      SHIFT: begin
        fin_res = a_q;
        fin_c   = sc;
        fin_v   = 1'b0;
        fin_go  = (cnt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      sc     <= 1'b0;
      cnt    <= '0;
      result <= '0;
      N_flag <= 1'b0;
      Z      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fin_go) begin
        result <= fin_res;
        N_flag <= fin_res[N-1];
        Z      <= (fin_res == '0);
        C      <= fin_c;
        V      <= fin_v;
        busy   <= 1'b0;
        done   <= 1'b1;
        state  <= FIN;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= control;
              acc   <= '0;
              mcand <= {{N{1'b0}}, A};
              sc    <= 1'b0;
              busy  <= 1'b1;
              if (control == OP_MUL) begin
                cnt   <= CNT_W'(N);
                state <= MUL;
              end else if (is_shift(control)) begin
                cnt   <= shift_count(B);
                state <= SHIFT;
              end else begin
                cnt   <= '0;
                state <= EXEC;
              end
            end
          end
          MUL: begin
            // One multiplier bit per step, LSB first.
            if (b_q[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            b_q   <= b_q >> 1;
            cnt   <= cnt - CNT_W'(1);
          end
          SHIFT: begin
            if (op_q == OP_SHL) begin
              sc  <= a_q[N-1];
              a_q <= a_q << 1;
            end else begin
              sc  <= a_q[0];
              a_q <= a_q >> 1;
            end
            cnt <= cnt - CNT_W'(1);
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   control;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] result;
  logic         N_flag;
  logic         Z;
  logic         C;
  logic         V;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_bad    = 0;

  logic [N-1:0] exp_q[$];

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .control   (control),
    .A         (A),
    .B         (B),
    .result    (result),
    .N_flag    (N_flag),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one op and checks latency, busy/done behaviour, result and flags.
  // poke=1 pulses a conflicting start in cycle 4, which must be ignored.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] e_res, input logic e_n, input logic e_z,
                        input logic e_c, input logic e_v, input int e_lat,
                        input bit poke);
    int lat;
    int busy_cycles;
    logic [N-1:0] e;
    @(negedge clk);
    start   = 1'b1;
    control = op;
    A       = a;
    B       = b;
    exp_q.push_back(e_res);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
    control = OP_AND;
    lat = 1;
    busy_cycles = 0;
    check_eq({name, ".busy_on_accept"}, {31'd0, busy}, 32'd1);
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (poke && lat == 4) begin
        start = 1'b1; control = OP_ADD; A = 8'hFF; B = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      check_eq({name, ".timeout"}, {31'd0, done}, 32'd1);
      return;
    end
    check_eq({name, ".latency"}, lat, e_lat);
    if (op == OP_MUL) check_eq({name, ".busy_cycles"}, busy_cycles, e_lat - 1);
    e = exp_q.pop_front();
    check_eq({name, ".result"}, {24'd0, result}, {24'd0, e});
    check_eq({name, ".N"},      {31'd0, N_flag}, {31'd0, e_n});
    check_eq({name, ".Z"},      {31'd0, Z},      {31'd0, e_z});
    check_eq({name, ".C"},      {31'd0, C},      {31'd0, e_c});
    check_eq({name, ".V"},      {31'd0, V},      {31'd0, e_v});
    check_eq({name, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    check_eq({name, ".state_fin"}, {29'd0, dbg_state}, {29'd0, FIN});
    @(posedge clk);
    #1;
    check_eq({name, ".done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({name, ".result_hold"}, {24'd0, result}, {24'd0, e});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; control = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.result", {24'd0, result}, 32'd0);
    check_eq("rst.flags",  {28'd0, N_flag, Z, C, V}, 32'd0);
    check_eq("rst.busy",   {31'd0, busy}, 32'd0);
    check_eq("rst.done",   {31'd0, done}, 32'd0);
    check_eq("rst.state",  {29'd0, dbg_state}, {29'd0, IDLE});
    @(negedge clk);
    rst = 1'b0;

    //          name        op      A      B      res    N     Z     C     V    lat poke
    run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1,  2, 1'b0);
    run_op("add_wrap", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0,  2, 1'b0);
    run_op("sub_brw",  OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0,  2, 1'b0);
    run_op("sub_ovf",  OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1,  2, 1'b0);
    run_op("mul_hi",   OP_MUL, 8'h10, 8'h11, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1'b1);
    run_op("mul_lo",   OP_MUL, 8'h03, 8'h05, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    run_op("shl_1",    OP_SHL, 8'h81, 8'd1,  8'h02, 1'b0, 1'b0, 1'b1, 1'b0,  3, 1'b0);
    run_op("shr_0",    OP_SHR, 8'h81, 8'd0,  8'h81, 1'b1, 1'b0, 1'b0, 1'b0,  2, 1'b0);
    run_op("shl_12",   OP_SHL, 8'hFF, 8'd12, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b0);
    run_op("shr_1",    OP_SHR, 8'h81, 8'd1,  8'h40, 1'b0, 1'b0, 1'b1, 1'b0,  3, 1'b0);
    run_op("shr_8",    OP_SHR, 8'h80, 8'd8,  8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b0);
    run_op("xor_zero", OP_XOR, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,  2, 1'b0);
    run_op("and",      OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0,  2, 1'b0);
    run_op("undef3",   4'd3,   8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,  2, 1'b0);
    run_op("or",       OP_OR,  8'h0F, 8'h80, 8'h8F, 1'b1, 1'b0, 1'b0, 1'b0,  2, 1'b0);

    // Abort a multiply with reset in cycle 4.
    @(negedge clk);
    start = 1'b1; control = OP_MUL; A = 8'h03; B = 8'h05;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort.result", {24'd0, result}, 32'd0);
    check_eq("abort.flags",  {28'd0, N_flag, Z, C, V}, 32'd0);
    check_eq("abort.busy",   {31'd0, busy}, 32'd0);
    check_eq("abort.done",   {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort.no_done", {31'd0, done}, 32'd0);
    check_eq("abort.state",   {29'd0, dbg_state}, {29'd0, IDLE});
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      check_eq("abort.quiet", {30'd0, busy, done}, 32'd0);
    end

    run_op("add_after", OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
